id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage sitting directly downstream of the register file read ports. It:
- latches decoded fields plus `rs1`/`rs2` operand data into an EX register;
- tracks in-flight destination writes in a per-register scoreboard and stalls decode on read-after-write hazards;
- applies writeback-to-operand bypass, since the register file itself has no write-through path.

## Interface
Parameters:
- XLEN, 32, data width
- REG_NUM, 32, architectural register count; register addresses are 5 bits
- OP_W, 16, width of the opaque decoded-operation bundle

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  stage accepts the instruction this cycle
- id_pc_i  in  XLEN  instruction address
- id_op_i  in  OP_W  decoded operation bundle
- id_imm_i  in  XLEN  immediate
- id_rs1_addr_i / id_rs2_addr_i  in  5  source register indices
- id_rs1_use_i / id_rs2_use_i  in  1  source register is actually read
- id_rs1_data_i / id_rs2_data_i  in  XLEN  operand data from the register file read ports
- id_rd_addr_i  in  5  destination register
- id_rd_we_i  in  1  instruction writes rd
- wb_we_i  in  1  writeback retires a register write this cycle
- wb_rd_addr_i  in  5  writeback destination
- wb_rd_data_i  in  XLEN  writeback data
- flush_i  in  1  kill the EX-held instruction and refuse input
- ex_valid_o  out  1  EX register holds a valid instruction
- ex_ready_i  in  1  execute consumes the instruction
- ex_pc_o, ex_op_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_we_o  out  matching widths  registered copies of the decode fields

## Operation
- accept = id_valid_i & id_ready_o.
- id_ready_o = !flush_i & (!ex_valid_o | ex_ready_i) & !hazard. It is combinational.
- Scoreboard: a 2-bit counter cnt[r] per register r = 1..31. x0 has no counter and is never pending.
- pending(r):
  - with bypass compiled in: cnt[r] > (wb_we_i & wb_rd_addr_i==r ? 1 : 0);
  - otherwise: cnt[r] != 0.
- hazard is asserted if any of:
  - id_rs1_use_i & rs1 != 0 & pending(rs1);
  - the same condition for rs2;
  - id_rd_we_i & rd != 0 & cnt[rd] == 3 (saturation stall).
- cnt[r] next value = cnt[r] + inc − dec_wb − dec_flush, where:
  - inc = accept & id_rd_we_i & rd == r, with rd != 0;
  - dec_wb = wb_we_i & wb_rd_addr_i == r, with r != 0;
  - dec_flush = flush_i & ex_valid_o & ex_rd_we_o & ex_rd_addr_o == r.
- All three terms may coincide on one register in the same cycle.
- inc and dec_flush are mutually exclusive, because no accept occurs during a flush.
- A decrement of a zero counter is a protocol error; the bench flags it.
- EX register update, in priority order:
  1. flush_i: ex_valid_o <= 0, and the held instruction is discarded. Execute must not treat a flush cycle as a transfer.
  2. accept: all ex_* fields load, ex_valid_o <= 1.
  3. ex_ready_i: ex_valid_o <= 0.
  4. Otherwise hold. All ex_* outputs stay stable while ex_valid_o & !ex_ready_i.
- Operand data loaded into the EX register:
  - 0 if the source address is 0;
  - wb_rd_data_i on a same-cycle writeback address match, when bypass is compiled in;
  - id_rsN_data_i otherwise.
- ex_rd_we_o loads id_rd_we_i & (rd != 0).

## Timing
- Reset values: ex_valid_o=0; all ex_* data fields 0; all cnt=0. id_ready_o is then 1 whenever flush_i is low.
- Latency is 1 cycle from accept to ex_valid_o. Throughput is 1 instruction per cycle when there are no hazards and ex_ready_i is held high.
- Without bypass, a dependent instruction is accepted no earlier than the cycle after its producer's wb_we_i.
- With bypass, the dependent instruction may be accepted in the producer's writeback cycle itself.
- If reset is asserted mid-operation, the in-flight EX instruction and all scoreboard state are discarded in one cycle.

## Configuration
- WB_BYPASS_EN defined:
  - the same-cycle writeback match both clears pending() and forwards wb_rd_data_i into the latched operand.
- WB_BYPASS_EN undefined:
  - no forwarding path;
  - operands come only from the register file, and pending() ignores the writeback of the current cycle.

## Test plan
- Reset, then idle: ex_valid_o=0, ex_rs1_data_o=0, id_ready_o=1; all counters 0.
- Back-to-back independent instructions, id_valid_i=1, ex_ready_i=1, at pc 0x00,0x04,0x08 -> ex_pc_o shows 0x00,0x04,0x08 on consecutive cycles, each one cycle after accept.
- Write x5, then an instruction reading x5 -> id_ready_o=0 until writeback.
  - With WB_BYPASS_EN: wb_we_i with x5=0xDEADBEEF gives accept in that cycle and ex_rs1_data_o=0xDEADBEEF.
  - Without WB_BYPASS_EN: accept occurs one cycle later.
- Hold ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> all ex_* outputs are stable and id_ready_o=0; release -> the next instruction loads.
- EX holds a write to x7, flush_i pulse -> ex_valid_o=0 next cycle and cnt[7]=0. A following read of x7 is accepted without stall, using the register file data.
- Saturation and x0:
  - three in-flight writes to x9 -> a fourth write to x9 stalls until one wb_we_i to x9;
  - reads of x0 never stall, and x0 operands are 0 even when id_rs1_data_i=0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with a per-register
// write scoreboard (RAW and saturation stalls) and an optional
// writeback-to-operand bypass.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - a same-cycle writeback clears the hazard on that register and
//               its data is forwarded into the latched operand.
//   undefined - operands come only from the register file read ports; a
//               dependent instruction waits until the cycle after writeback.
module id_ex_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned OP_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,

  // Decode side
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [OP_W-1:0] id_op_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_use_i,
  input  logic            id_rs2_use_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_we_i,

  // Writeback side
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_rd_data_i,

  // Pipeline control
  input  logic            flush_i,

  // Execute side
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [OP_W-1:0] ex_op_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_rd_we_o
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Scoreboard: number of accepted-but-not-retired writes per register.
  // Entry 0 exists only to keep indexing uniform and is held at zero.
  logic [CW-1:0] cnt_q [REG_NUM];
  logic [CW-1:0] cnt_d [REG_NUM];

  logic            accept;
  logic            hazard;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            rd_sat;
  logic [CW-1:0]   rs1_cnt;
  logic [CW-1:0]   rs2_cnt;
  logic [CW-1:0]   rd_cnt;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef WB_BYPASS_EN
  logic rs1_wb_hit;
  logic rs2_wb_hit;
`else
  // Writeback data has no consumer when forwarding is compiled out.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_rd_data_i;
`endif

  // Handshake toward decode; combinational by design.
  assign id_ready_o = !flush_i && (!ex_valid_o || ex_ready_i) && !hazard;
  assign accept     = id_valid_i && id_ready_o;

  // RAW and saturation hazard detection against the scoreboard.
  always_comb begin
    rs1_cnt  = cnt_q[id_rs1_addr_i];
    rs2_cnt  = cnt_q[id_rs2_addr_i];
    rd_cnt   = cnt_q[id_rd_addr_i];
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
`ifdef WB_BYPASS_EN
    rs1_wb_hit = wb_we_i && (wb_rd_addr_i == id_rs1_addr_i);
    rs2_wb_hit = wb_we_i && (wb_rd_addr_i == id_rs2_addr_i);
    // A write retiring this cycle is covered by the forwarding path.
    rs1_pend   = rs1_cnt > CW'(rs1_wb_hit);
    rs2_pend   = rs2_cnt > CW'(rs2_wb_hit);
`else
    rs1_pend   = rs1_cnt != '0;
    rs2_pend   = rs2_cnt != '0;
`endif
    rd_sat = id_rd_we_i && (id_rd_addr_i != '0) && (rd_cnt == CNT_MAX);
    hazard = (id_rs1_use_i && (id_rs1_addr_i != '0) && rs1_pend)
          || (id_rs2_use_i && (id_rs2_addr_i != '0) && rs2_pend)
          || rd_sat;
  end

  // Scoreboard next state: issue increments, writeback and flush decrement.
  always_comb begin
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      cnt_d[r] = cnt_q[r]
               + CW'(accept && id_rd_we_i && (id_rd_addr_i == AW'(r)))
               - CW'(wb_we_i && (wb_rd_addr_i == AW'(r)))
               - CW'(flush_i && ex_valid_o && ex_rd_we_o
                     && (ex_rd_addr_o == AW'(r)));
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Operand selection: x0 reads zero, then optional writeback forward.
  always_comb begin
    rs1_val = id_rs1_data_i;
    rs2_val = id_rs2_data_i;
`ifdef WB_BYPASS_EN
    if (rs1_wb_hit) begin
      rs1_val = wb_rd_data_i;
    end
    if (rs2_wb_hit) begin
      rs2_val = wb_rd_data_i;
    end
`endif
    if (id_rs1_addr_i == '0) begin
      rs1_val = '0;
    end
    if (id_rs2_addr_i == '0) begin
      rs2_val = '0;
    end
  end

  // EX register: flush beats accept beats consume; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_op_o       <= '0;
      ex_imm_o      <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_rd_we_o    <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= id_pc_i;
      ex_op_o       <= id_op_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_data_o <= rs1_val;
      ex_rs2_data_o <= rs2_val;
      ex_rd_addr_o  <= id_rd_addr_i;
      ex_rd_we_o    <= id_rd_we_i && (id_rd_addr_i != '0);
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table-driven bench for id_ex_stage, plus short
// hand-written sequences for stall hold, flush and mid-operation reset.
// Honours WB_BYPASS_EN the same way the design does.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [15:0] id_op;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_use;
  logic        id_rs2_use;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [15:0] ex_op;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;

  id_ex_stage #(.XLEN(32), .REG_NUM(32), .OP_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(id_pc), .id_op_i(id_op), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_rd_addr_i(id_rd_addr), .id_rd_we_i(id_rd_we),
    .wb_we_i(wb_we), .wb_rd_addr_i(wb_rd_addr), .wb_rd_data_i(wb_rd_data),
    .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_pc_o(ex_pc), .ex_op_o(ex_op), .ex_imm_o(ex_imm),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_rd_addr_o(ex_rd_addr), .ex_rd_we_o(ex_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, rdwe;
    logic [31:0] d1, d2;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        flush;
    logic        exrdy;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int proto_err = 0;
  int model_cnt [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    v.exrdy     = 1'b1;
    v.exp_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t ins(input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [31:0] d1, input logic [4:0] rs2,
                               input logic [31:0] d2, input logic [4:0] rd,
                               input logic we);
    vec_t v;
    v = nop();
    v.valid = 1'b1; v.pc = pc;
    v.rs1 = rs1; v.d1 = d1; v.use1 = 1'b1;
    v.rs2 = rs2; v.d2 = d2; v.use2 = 1'b1;
    v.rd = rd; v.rdwe = we;
    return v;
  endfunction

  function automatic vec_t wb(input vec_t vi, input logic [4:0] rd, input logic [31:0] data);
    vec_t v;
    v = vi;
    v.wbwe = 1'b1; v.wbrd = rd; v.wbd = data;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic rdy, input logic val,
                              input logic [31:0] pc, input logic [31:0] r1,
                              input logic [31:0] r2);
    vec_t v;
    v = vi;
    v.exp_ready = rdy; v.exp_valid = val;
    v.exp_pc = pc; v.exp_rs1 = r1; v.exp_rs2 = r2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid    = v.valid;
    id_pc       = v.pc;
    id_op       = v.pc[15:0];
    id_imm      = v.pc + 32'h100;
    id_rs1_addr = v.rs1;
    id_rs2_addr = v.rs2;
    id_rs1_use  = v.use1;
    id_rs2_use  = v.use2;
    id_rs1_data = v.d1;
    id_rs2_data = v.d2;
    id_rd_addr  = v.rd;
    id_rd_we    = v.rdwe;
    wb_we       = v.wbwe;
    wb_rd_addr  = v.wbrd;
    wb_rd_data  = v.wbd;
    flush       = v.flush;
    ex_ready    = v.exrdy;
  endtask

  // One cycle: check ready mid-cycle, then the EX register after the edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk($sformatf("%s ready", tag), 32'(id_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    chk($sformatf("%s ex_valid", tag), 32'(ex_valid), 32'(v.exp_valid));
    chk($sformatf("%s ex_pc", tag), ex_pc, v.exp_pc);
    chk($sformatf("%s ex_op", tag), 32'(ex_op), 32'(v.exp_pc[15:0]));
    chk($sformatf("%s ex_rs1", tag), ex_rs1_data, v.exp_rs1);
    chk($sformatf("%s ex_rs2", tag), ex_rs2_data, v.exp_rs2);
  endtask

  // Stimulus legality: every decrement must hit a register with a write in flight.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model_cnt[i] = 0;
    end else begin
      if (wb_we && wb_rd_addr != 5'd0) begin
        if (model_cnt[wb_rd_addr] == 0) proto_err++;
        else model_cnt[wb_rd_addr]--;
      end
      if (flush && ex_valid && ex_rd_we) begin
        if (model_cnt[ex_rd_addr] == 0) proto_err++;
        else model_cnt[ex_rd_addr]--;
      end
      if (id_valid && id_ready && id_rd_we && id_rd_addr != 5'd0)
        model_cnt[id_rd_addr]++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  vec_t vq[$];
  vec_t v;

  initial begin
    // Reset and idle
    rst = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_pc", ex_pc, 32'd0);
    chk("reset ex_rs1", ex_rs1_data, 32'd0);
    chk("reset ex_rd_we", 32'(ex_rd_we), 32'd0);
    @(negedge clk);
    chk("reset ready", 32'(id_ready), 32'd1);
    flush = 1'b1;
    #1 chk("flush blocks ready", 32'(id_ready), 32'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back independent instructions, x0 operand
    vq.push_back(ex(ins(32'h00, 5'd1, 32'h11, 5'd0, 32'hFFFF_FFFF, 5'd2, 1'b0), 1, 1, 32'h00, 32'h11, 0));
    vq.push_back(ex(ins(32'h04, 5'd1, 32'h22, 5'd0, 32'hFFFF_FFFF, 5'd2, 1'b0), 1, 1, 32'h04, 32'h22, 0));
    vq.push_back(ex(ins(32'h08, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 5'd2, 1'b0), 1, 1, 32'h08, 0, 0));
    vq.push_back(ex(nop(), 1, 0, 32'h08, 0, 0));
    // RAW on x5
    vq.push_back(ex(ins(32'h10, 5'd1, 32'h44, 5'd0, 32'h0, 5'd5, 1'b1), 1, 1, 32'h10, 32'h44, 0));
    vq.push_back(ex(ins(32'h14, 5'd5, 32'h55, 5'd0, 32'h0, 5'd6, 1'b0), 0, 0, 32'h10, 32'h44, 0));
    vq.push_back(ex(ins(32'h14, 5'd5, 32'h55, 5'd0, 32'h0, 5'd6, 1'b0), 0, 0, 32'h10, 32'h44, 0));
`ifdef WB_BYPASS_EN
    vq.push_back(ex(wb(ins(32'h14, 5'd5, 32'h55, 5'd0, 32'h0, 5'd6, 1'b0), 5'd5, 32'hDEAD_BEEF),
                    1, 1, 32'h14, 32'hDEAD_BEEF, 0));
    vq.push_back(ex(nop(), 1, 0, 32'h14, 32'hDEAD_BEEF, 0));
`else
    vq.push_back(ex(wb(ins(32'h14, 5'd5, 32'h55, 5'd0, 32'h0, 5'd6, 1'b0), 5'd5, 32'hDEAD_BEEF),
                    0, 0, 32'h10, 32'h44, 0));
    vq.push_back(ex(ins(32'h14, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd6, 1'b0), 1, 1, 32'h14, 32'hDEAD_BEEF, 0));
`endif
    vq.push_back(ex(nop(), 1, 0, 32'h14, 32'hDEAD_BEEF, 0));
    // Saturation on x9
    vq.push_back(ex(ins(32'h20, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 1, 1, 32'h20, 0, 0));
    vq.push_back(ex(ins(32'h24, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 1, 1, 32'h24, 0, 0));
    vq.push_back(ex(ins(32'h28, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 1, 1, 32'h28, 0, 0));
    vq.push_back(ex(ins(32'h2C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 0, 0, 32'h28, 0, 0));
    vq.push_back(ex(wb(ins(32'h2C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 5'd9, 32'h1), 0, 0, 32'h28, 0, 0));
    vq.push_back(ex(ins(32'h2C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1), 1, 1, 32'h2C, 0, 0));
    vq.push_back(ex(wb(nop(), 5'd9, 32'h2), 1, 0, 32'h2C, 0, 0));
    vq.push_back(ex(wb(nop(), 5'd9, 32'h3), 1, 0, 32'h2C, 0, 0));
    vq.push_back(ex(wb(nop(), 5'd9, 32'h4), 1, 0, 32'h2C, 0, 0));
    vq.push_back(ex(ins(32'h30, 5'd0, 32'h0, 5'd9, 32'h99, 5'd0, 1'b0), 1, 1, 32'h30, 0, 32'h99));
    vq.push_back(ex(nop(), 1, 0, 32'h30, 0, 32'h99));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // Back-pressure: EX holds for 3 cycles, then the waiting instruction loads
    apply(ex(ins(32'h40, 5'd3, 32'h123, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0), 1, 1, 32'h40, 32'h123, 0), "hold load");
    v = ins(32'h44, 5'd3, 32'h456, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0);
    v.exrdy = 1'b0;
    for (int i = 0; i < 3; i++) apply(ex(v, 0, 1, 32'h40, 32'h123, 0), $sformatf("hold%0d", i));
    chk("hold ex_imm", ex_imm, 32'h140);
    apply(ex(ins(32'h44, 5'd3, 32'h456, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0), 1, 1, 32'h44, 32'h456, 0), "hold release");
    apply(ex(nop(), 1, 0, 32'h44, 32'h456, 0), "hold idle");

    // Flush of an in-flight x7 writer clears its scoreboard entry
    apply(ex(ins(32'h50, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 5'd7, 1'b1), 1, 1, 32'h50, 0, 0), "flush load");
    chk("flush ex_rd_we", 32'(ex_rd_we), 32'd1);
    v = ins(32'h54, 5'd7, 32'h777, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0);
    v.exrdy = 1'b0;
    v.flush = 1'b1;
    apply(ex(v, 0, 0, 32'h50, 0, 0), "flush pulse");
    apply(ex(ins(32'h54, 5'd7, 32'h777, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0), 1, 1, 32'h54, 32'h777, 0), "flush read x7");
    apply(ex(nop(), 1, 0, 32'h54, 32'h777, 0), "flush idle");

    // Reset in the middle of operation drops EX and the scoreboard
    apply(ex(ins(32'h60, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 5'd12, 1'b1), 1, 1, 32'h60, 0, 0), "mrst load");
    v = ins(32'h64, 5'd12, 32'hCAFE_F00D, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0);
    v.exrdy = 1'b0;
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst ex_valid", 32'(ex_valid), 32'd0);
    chk("mrst ex_pc", ex_pc, 32'd0);
    chk("mrst ex_rs1", ex_rs1_data, 32'd0);
    apply(ex(ins(32'h64, 5'd12, 32'hCAFE_F00D, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0), 1, 1, 32'h64, 32'hCAFE_F00D, 0), "mrst read x12");
    apply(ex(nop(), 1, 0, 32'h64, 32'hCAFE_F00D, 0), "mrst idle");

    chk("protocol decrement of idle counter", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
